// File: rtl/sha_nonce_scheduler_pkg.sv
// Shared definitions for the nonce sweep scheduler: FSM state encoding and the
// default nonce width.
package sha_nonce_scheduler_pkg;

    localparam int NONCE_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_EVAL   = 3'd3,
        S_FIN    = 3'd4
    } sched_state_t;

endpackage

// File: rtl/sha_found_encoder.sv
// Lowest-set-bit priority encoder over the per-core found vector; the lowest
// core index corresponds to the lowest nonce in the batch.
module sha_found_encoder #(
    parameter int CORES = 2,
    parameter int IDX_W = 8
) (
    input  logic [CORES-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan downward so the last assignment is the lowest set bit.
        for (int i = CORES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Sweeps an inclusive nonce range across the parallel SHA core array in batches
// of CORES nonces and reports the lowest winning nonce, or exhaustion/abort.
module sha_nonce_scheduler
    import sha_nonce_scheduler_pkg::*;
#(
    parameter int CORES   = 2,
    parameter int NONCE_W = NONCE_W_DEFAULT,
    parameter int IDX_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic               fsm_ready,
    input  logic               digest_valid,
    input  logic [CORES-1:0]   found,
    output logic               core_start,
    output logic [NONCE_W-1:0] batch_base,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic [NONCE_W-1:0] hit_nonce,
    output logic [IDX_W-1:0]   hit_core,
    output logic [NONCE_W-1:0] batch_cnt
);

    sched_state_t state, state_nxt;

    logic [NONCE_W-1:0] base_q;
    logic [NONCE_W-1:0] end_q;
    logic [CORES-1:0]   found_q;
    logic               hit_q;
    logic [NONCE_W-1:0] hit_nonce_q;
    logic [IDX_W-1:0]   hit_core_q;
    logic [NONCE_W-1:0] batch_cnt_q;

    logic [NONCE_W:0]   base_ext;
    logic [NONCE_W:0]   end_ext;
    logic [NONCE_W:0]   next_ext;
    logic               range_done;
    logic [CORES-1:0]   valid_mask;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;

    function automatic logic [NONCE_W-1:0] sat_inc(input logic [NONCE_W-1:0] v);
        return (&v) ? v : v + NONCE_W'(1);
    endfunction

    // One extra bit keeps the end-of-range tests exact at the top of the nonce space.
    assign base_ext   = {1'b0, base_q};
    assign end_ext    = {1'b0, end_q};
    assign next_ext   = base_ext + (NONCE_W + 1)'(CORES);
    assign range_done = (next_ext > end_ext);

    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < CORES; i++) begin
            valid_mask[i] = ((base_ext + (NONCE_W + 1)'(i)) <= end_ext);
        end
    end

    sha_found_encoder #(
        .CORES (CORES),
        .IDX_W (IDX_W)
    ) u_found_encoder (
        .vec (found_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = (nonce_start > nonce_end) ? S_FIN : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (abort) begin
                    state_nxt = S_FIN;
                end else if (fsm_ready) begin
                    core_start = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_FIN;
                end else if (digest_valid) begin
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                if (abort || enc_any || range_done) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q      <= '0;
            end_q       <= '0;
            found_q     <= '0;
            hit_q       <= 1'b0;
            hit_nonce_q <= '0;
            hit_core_q  <= '0;
            batch_cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        base_q      <= nonce_start;
                        end_q       <= nonce_end;
                        batch_cnt_q <= '0;
                        hit_q       <= 1'b0;
                        hit_nonce_q <= '0;
                        hit_core_q  <= '0;
                    end
                end
                S_LAUNCH: begin
                    if (core_start) begin
                        batch_cnt_q <= sat_inc(batch_cnt_q);
                    end
                end
                S_WAIT: begin
                    if (!abort && digest_valid) begin
                        found_q <= found & valid_mask;
                    end
                end
                S_EVAL: begin
                    if (!abort) begin
                        if (enc_any) begin
                            hit_q       <= 1'b1;
                            hit_core_q  <= enc_idx;
                            hit_nonce_q <= base_q + NONCE_W'(enc_idx);
                        end else if (!range_done) begin
                            base_q <= next_ext[NONCE_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != S_IDLE);
    assign batch_base = base_q;
    assign hit        = hit_q;
    assign hit_nonce  = hit_nonce_q;
    assign hit_core   = hit_core_q;
    assign batch_cnt  = batch_cnt_q;

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench for sha_nonce_scheduler with CORES=2, NONCE_W=32.
module tb_sha_nonce_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] nonce_start = '0;
    logic [31:0] nonce_end = '0;
    logic        fsm_ready = 1'b1;
    logic        digest_valid = 1'b0;
    logic [1:0]  found = '0;
    logic        core_start;
    logic [31:0] batch_base;
    logic        busy;
    logic        done;
    logic        hit;
    logic [31:0] hit_nonce;
    logic [7:0]  hit_core;
    logic [31:0] batch_cnt;

    int tests = 0;
    int fails = 0;

    sha_nonce_scheduler #(.CORES(2), .NONCE_W(32), .IDX_W(8)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .fsm_ready(fsm_ready), .digest_valid(digest_valid), .found(found),
        .core_start(core_start), .batch_base(batch_base), .busy(busy),
        .done(done), .hit(hit), .hit_nonce(hit_nonce), .hit_core(hit_core),
        .batch_cnt(batch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_sweep(input logic [31:0] s, input logic [31:0] e);
        step();
        go = 1'b1;
        nonce_start = s;
        nonce_end = e;
        step();
        go = 1'b0;
        #1;
    endtask

    task automatic pulse_digest(input logic [1:0] f);
        step();
        digest_valid = 1'b1;
        found = f;
        step();
        digest_valid = 1'b0;
        found = '0;
        #1;
    endtask

    task automatic wait_start(input int max_cyc, output int n);
        n = 0;
        while (!core_start && n < max_cyc) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        while (!done && n < max_cyc) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        step();
        step();
        tests++;
        if ({core_start, busy, done, hit} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctrl: got %b want 0000", {core_start, busy, done, hit});
        end
        tests++;
        if ({batch_base, batch_cnt, hit_nonce, hit_core} !== '0) begin
            fails++; $display("FAIL reset_data: base=%h cnt=%h nonce=%h core=%h want all 0",
                              batch_base, batch_cnt, hit_nonce, hit_core);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_hit_second_batch();
        int n;
        start_sweep(32'h10, 32'h1F);
        tests++;
        if (core_start !== 1'b1 || batch_base !== 32'h10) begin
            fails++; $display("FAIL t1_start1: core_start=%b base=%h want 1 / 10", core_start, batch_base);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL t1_busy: got %b want 1", busy);
        end
        pulse_digest(2'b00);
        wait_start(8, n);
        tests++;
        if (n !== 1 || core_start !== 1'b1) begin
            fails++; $display("FAIL t1_start2_latency: waited %0d start=%b want 1 / 1", n, core_start);
        end
        tests++;
        if (batch_base !== 32'h12 || batch_cnt !== 32'd1) begin
            fails++; $display("FAIL t1_base2: base=%h cnt=%0d want 12 / 1", batch_base, batch_cnt);
        end
        pulse_digest(2'b10);
        wait_done(8, n);
        tests++;
        if (n !== 1 || done !== 1'b1) begin
            fails++; $display("FAIL t1_done_latency: waited %0d done=%b want 1 / 1", n, done);
        end
        tests++;
        if (hit !== 1'b1 || hit_nonce !== 32'h13 || hit_core !== 8'd1 || batch_cnt !== 32'd2) begin
            fails++; $display("FAIL t1_result: hit=%b nonce=%h core=%0d cnt=%0d want 1 / 13 / 1 / 2",
                              hit, hit_nonce, hit_core, batch_cnt);
        end
        step();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || hit_nonce !== 32'h13) begin
            fails++; $display("FAIL t1_after: done=%b busy=%b nonce=%h want 0 / 0 / 13", done, busy, hit_nonce);
        end
    endtask

    task automatic test_simultaneous_hits();
        int n;
        start_sweep(32'h40, 32'h4F);
        pulse_digest(2'b11);
        wait_done(8, n);
        tests++;
        if (done !== 1'b1 || hit !== 1'b1 || hit_core !== 8'd0 || hit_nonce !== 32'h40) begin
            fails++; $display("FAIL t2_lowest: done=%b hit=%b core=%0d nonce=%h want 1 / 1 / 0 / 40",
                              done, hit, hit_core, hit_nonce);
        end
        step();
    endtask

    task automatic test_exhausted_odd_range();
        int n;
        start_sweep(32'd5, 32'd9);
        // go while busy must not restart the sweep
        go = 1'b1;
        nonce_start = 32'h77;
        pulse_digest(2'b00);
        go = 1'b0;
        wait_start(8, n);
        tests++;
        if (core_start !== 1'b1 || batch_base !== 32'd7) begin
            fails++; $display("FAIL t3_base2: start=%b base=%0d want 1 / 7", core_start, batch_base);
        end
        pulse_digest(2'b00);
        wait_start(8, n);
        tests++;
        if (core_start !== 1'b1 || batch_base !== 32'd9) begin
            fails++; $display("FAIL t3_base3: start=%b base=%0d want 1 / 9", core_start, batch_base);
        end
        pulse_digest(2'b10);
        wait_done(8, n);
        tests++;
        if (done !== 1'b1 || hit !== 1'b0 || batch_cnt !== 32'd3) begin
            fails++; $display("FAIL t3_masked_end: done=%b hit=%b cnt=%0d want 1 / 0 / 3", done, hit, batch_cnt);
        end
        step();
    endtask

    task automatic test_top_of_range();
        int n;
        start_sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        tests++;
        if (core_start !== 1'b1 || batch_base !== 32'hFFFF_FFFE) begin
            fails++; $display("FAIL t4_start: start=%b base=%h want 1 / fffffffe", core_start, batch_base);
        end
        pulse_digest(2'b00);
        wait_done(8, n);
        tests++;
        if (n !== 1 || done !== 1'b1 || hit !== 1'b0) begin
            fails++; $display("FAIL t4_done: waited %0d done=%b hit=%b want 1 / 1 / 0", n, done, hit);
        end
        tests++;
        if (batch_cnt !== 32'd1 || batch_base !== 32'hFFFF_FFFE) begin
            fails++; $display("FAIL t4_nowrap: cnt=%0d base=%h want 1 / fffffffe", batch_cnt, batch_base);
        end
        step();
    endtask

    task automatic test_empty_range();
        start_sweep(32'd9, 32'd5);
        tests++;
        if (done !== 1'b1 || hit !== 1'b0 || core_start !== 1'b0 || batch_cnt !== 32'd0) begin
            fails++; $display("FAIL empty_range: done=%b hit=%b start=%b cnt=%0d want 1 / 0 / 0 / 0",
                              done, hit, core_start, batch_cnt);
        end
        step();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL empty_after: done=%b busy=%b want 0 / 0", done, busy);
        end
    endtask

    task automatic test_abort();
        // go and abort together in IDLE: go wins
        step();
        go = 1'b1;
        abort = 1'b1;
        nonce_start = 32'h100;
        nonce_end = 32'h1FF;
        step();
        go = 1'b0;
        abort = 1'b0;
        #1;
        tests++;
        if (core_start !== 1'b1 || busy !== 1'b1 || batch_base !== 32'h100) begin
            fails++; $display("FAIL t5_go_wins: start=%b busy=%b base=%h want 1 / 1 / 100",
                              core_start, busy, batch_base);
        end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        tests++;
        if (done !== 1'b1 || hit !== 1'b0) begin
            fails++; $display("FAIL t5_abort_wait: done=%b hit=%b want 1 / 0", done, hit);
        end
        step();
        digest_valid = 1'b1;
        found = 2'b11;
        step();
        digest_valid = 1'b0;
        found = '0;
        step();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || core_start !== 1'b0 || batch_cnt !== 32'd1) begin
            fails++; $display("FAIL t5_stray_digest: busy=%b done=%b hit=%b start=%b cnt=%0d want 0 0 0 0 1",
                              busy, done, hit, core_start, batch_cnt);
        end
        fsm_ready = 1'b0;
        start_sweep(32'h200, 32'h2FF);
        step();
        tests++;
        if (core_start !== 1'b0 || busy !== 1'b1 || batch_cnt !== 32'd0) begin
            fails++; $display("FAIL t5_not_ready: start=%b busy=%b cnt=%0d want 0 / 1 / 0", core_start, busy, batch_cnt);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        tests++;
        if (done !== 1'b1 || hit !== 1'b0 || batch_cnt !== 32'd0) begin
            fails++; $display("FAIL t5_abort_launch: done=%b hit=%b cnt=%0d want 1 / 0 / 0", done, hit, batch_cnt);
        end
        fsm_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_wait();
        int n;
        start_sweep(32'h20, 32'h2F);
        step();
        rst = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || core_start !== 1'b0 || hit !== 1'b0) begin
            fails++; $display("FAIL t6_async_ctrl: busy=%b done=%b start=%b hit=%b want 0 0 0 0",
                              busy, done, core_start, hit);
        end
        tests++;
        if (batch_cnt !== 32'd0 || batch_base !== 32'd0 || hit_nonce !== 32'd0 || hit_core !== 8'd0) begin
            fails++; $display("FAIL t6_async_data: cnt=%0d base=%h nonce=%h core=%0d want all 0",
                              batch_cnt, batch_base, hit_nonce, hit_core);
        end
        step();
        rst = 1'b1;
        step();
        start_sweep(32'h30, 32'h31);
        tests++;
        if (core_start !== 1'b1 || batch_base !== 32'h30 || batch_cnt !== 32'd0) begin
            fails++; $display("FAIL t6_clean_start: start=%b base=%h cnt=%0d want 1 / 30 / 0",
                              core_start, batch_base, batch_cnt);
        end
        pulse_digest(2'b01);
        wait_done(8, n);
        tests++;
        if (done !== 1'b1 || hit !== 1'b1 || hit_nonce !== 32'h30 || hit_core !== 8'd0 || batch_cnt !== 32'd1) begin
            fails++; $display("FAIL t6_result: done=%b hit=%b nonce=%h core=%0d cnt=%0d want 1 1 30 0 1",
                              done, hit, hit_nonce, hit_core, batch_cnt);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_hit_second_batch();
        test_simultaneous_hits();
        test_exhausted_odd_range();
        test_top_of_range();
        test_empty_range();
        test_abort();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
